// File: rtl/fifo_block_packer.sv
// rtl/fifo_block_packer.sv - packs 32-bit FIFO words into 128-bit AES blocks
// Purpose:
//   Pops WORDS words from the upstream data FIFO (one-cycle read latency),
//   shifts them into a block register and offers the block on a valid/ready
//   handshake, holding it stable until it is accepted.
// Ports:
//   clk_i         single clock, rising edge
//   reset_i       synchronous active-high reset (clears blk_data as well)
//   clear_i       synchronous abort of the partial or held block (keeps blk_data)
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_rd_o     FIFO pop request
//   fifo_data_i   FIFO read data, valid the cycle after fifo_rd_o
//   blk_data_o    assembled block, first word in the MSBs
//   blk_valid_o   block available
//   blk_ready_i   consumer accepts when blk_valid_o && blk_ready_i
//   word_count_o  words captured into the current block
module fifo_block_packer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     fifo_empty_i,
  output logic                     fifo_rd_o,
  input  logic [WORD_W-1:0]        fifo_data_i,
  output logic [WORD_W*WORDS-1:0]  blk_data_o,
  output logic                     blk_valid_o,
  input  logic                     blk_ready_i,
  output logic [CNT_W-1:0]         word_count_o
);

  localparam int BLK_W = WORD_W * WORDS;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    blk_data_q, blk_data_d;
  logic                blk_valid_q, blk_valid_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic                rd_pend_q, rd_pend_d;

  logic [CNT_W-1:0]    committed;
  logic [CNT_W-1:0]    wc_inc;
  logic                fifo_rd;
  logic                handshake;

  // Words already captured plus the one in flight; caps pops at WORDS per block.
  assign committed = word_count_q + CNT_W'(rd_pend_q);
  assign wc_inc    = word_count_q + CNT_W'(1);
  assign fifo_rd   = (state_q == FILL) && !fifo_empty_i && !clear_i && !reset_i
                     && (committed < WORDS_C);
  assign handshake = blk_valid_q && blk_ready_i;

  always_comb begin
    state_d      = state_q;
    blk_data_d   = blk_data_q;
    blk_valid_d  = blk_valid_q;
    word_count_d = word_count_q;
    rd_pend_d    = fifo_rd;

    case (state_q)
      FILL: begin
        // Read data arrives the cycle after the pop; shift it in then.
        if (rd_pend_q) begin
          blk_data_d   = {blk_data_q[BLK_W-WORD_W-1:0], fifo_data_i};
          word_count_d = wc_inc;
          if (wc_inc == WORDS_C) begin
            state_d     = FULL;
            blk_valid_d = 1'b1;
          end
        end
      end
      FULL: begin
        // blk_data is left as is; the next block overwrites it by shifting.
        if (handshake) begin
          state_d      = FILL;
          blk_valid_d  = 1'b0;
          word_count_d = '0;
        end
      end
    endcase

    // Clear beats a simultaneous handshake and discards any in-flight word.
    if (clear_i) begin
      state_d      = FILL;
      blk_valid_d  = 1'b0;
      word_count_d = '0;
      rd_pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= FILL;
      blk_data_q   <= '0;
      blk_valid_q  <= 1'b0;
      word_count_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_data_q   <= blk_data_d;
      blk_valid_q  <= blk_valid_d;
      word_count_q <= word_count_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  assign fifo_rd_o    = fifo_rd;
  assign blk_data_o   = blk_data_q;
  assign blk_valid_o  = blk_valid_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_fifo_block_packer.sv
// tb/tb_fifo_block_packer.sv - scoreboard bench for fifo_block_packer
module tb_fifo_block_packer;

  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int CNT_W  = 3;
  localparam int BLK_W  = WORD_W * WORDS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd;
  logic [WORD_W-1:0] fifo_data = '0;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_valid;
  logic              blk_ready = 1'b0;
  logic [CNT_W-1:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] fq[$];     // FIFO contents
  logic [WORD_W-1:0] part[$];   // model: words of the block being assembled
  logic [BLK_W-1:0]  sb[$];     // model: expected blocks in delivery order
  bit                mon_en = 1'b0;

  always #5 clk = ~clk;

  fifo_block_packer #(.WORD_W(WORD_W), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (clear),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .fifo_data_i  (fifo_data),
    .blk_data_o   (blk_data),
    .blk_valid_o  (blk_valid),
    .blk_ready_i  (blk_ready),
    .word_count_o (word_count)
  );

  task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Model: every WORDS pushed words form the next expected block.
  task automatic push_word(input logic [WORD_W-1:0] w);
    fq.push_back(w);
    part.push_back(w);
    if (part.size() == WORDS) begin
      sb.push_back({part[0], part[1], part[2], part[3]});
      part.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (blk_valid !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (blk_valid !== 1'b1) fail_now({name, "_timeout"});
  endtask

  // FIFO with one-cycle read latency.
  always begin
    logic rd_s;
    @(negedge clk);
    rd_s = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_s === 1'b1 && fq.size() > 0) fifo_data = fq.pop_front();
    #2;
    fifo_empty = (fq.size() == 0);
  end

  // Monitor: scoreboard pop on handshake plus protocol rules.
  logic             pv = 1'b0;
  logic             phs = 1'b0;
  logic             prc = 1'b0;
  logic [BLK_W-1:0] pd = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_rd === 1'b1) check("no_pop_when_empty", fifo_empty, 0);
      if (pv === 1'b1 && !phs && !prc) begin
        check("valid_held", blk_valid, 1);
        check("data_stable", blk_data, pd);
      end
      if (blk_valid === 1'b1 && blk_ready && !reset && !clear) begin
        if (sb.size() == 0) fail_now("unexpected_block");
        else check("block_data", blk_data, sb.pop_front());
      end
    end
    pv  = blk_valid;
    phs = blk_valid && blk_ready;
    prc = reset || clear;
    pd  = blk_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BLK_W-1:0] d0;
    logic [BLK_W-1:0] exp2;
    logic [CNT_W-1:0] seen[$];
    int rd_cnt;
    int pushed;
    int cyc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_fifo_rd", fifo_rd, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_blk_valid", blk_valid, 0);
    check("reset_word_count", word_count, 0);
    check("reset_blk_data", blk_data, 0);
    mon_en = 1'b1;

    // T1 basic block
    blk_ready = 1'b1;
    tick();
    push_word(32'h00112233);
    push_word(32'h44556677);
    push_word(32'h8899AABB);
    push_word(32'hCCDDEEFF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t1_rd_%0d", k), fifo_rd, (k < 4));
      check($sformatf("t1_valid_%0d", k), blk_valid, (k == 5));
      if (k == 5) check("t1_blk", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    end
    repeat (2) tick();

    // T2 backpressure
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    exp2 = sb[sb.size()-1];
    wait_valid(20, "t2_valid");
    d0 = blk_data;
    check("t2_block", d0, exp2);
    tick();
    for (int i = 0; i < 4; i++) push_word($urandom);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t2_rd_%0d", k), fifo_rd, 0);
      check($sformatf("t2_valid_%0d", k), blk_valid, 1);
      check($sformatf("t2_data_%0d", k), blk_data, d0);
    end
    tick();
    blk_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("t2_rise_%0d", k), blk_valid, (k == 6));
    end
    repeat (2) tick();

    // T3 starved source
    seen.delete();
    seen.push_back(word_count);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          tick();
          push_word($urandom);
          repeat (4) @(posedge clk);
        end
      end
      begin
        int k;
        k = 0;
        while (blk_valid !== 1'b1 && k < 60) begin
          @(negedge clk);
          k++;
          if (word_count != seen[seen.size()-1]) seen.push_back(word_count);
        end
      end
    join
    check("t3_steps", seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      check($sformatf("t3_wc_%0d", i), seen[i], i);
    repeat (2) tick();

    // T4 clear mid-block
    push_word($urandom);
    push_word($urandom);
    repeat (6) @(negedge clk);
    check("t4_wc_before", word_count, 2);
    tick();
    clear = 1'b1;
    part.delete();
    tick();
    clear = 1'b0;
    @(negedge clk);
    check("t4_wc_after", word_count, 0);
    tick();
    for (int i = 0; i < 4; i++) push_word($urandom);
    wait_valid(20, "t4_valid");
    repeat (2) tick();

    // T5 reset in FULL
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    wait_valid(20, "t5_valid");
    tick();
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("t5_rd_in_reset", fifo_rd, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_valid", blk_valid, 0);
    check("t5_data", blk_data, 0);
    check("t5_wc", word_count, 0);
    check("t5_rd", fifo_rd, 0);
    tick();

    // T6 single word available
    blk_ready = 1'b1;
    push_word($urandom);
    rd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_rd === 1'b1) rd_cnt++;
      check($sformatf("t6_valid_%0d", k), blk_valid, 0);
    end
    check("t6_rd_count", rd_cnt, 1);
    check("t6_wc", word_count, 1);
    tick();
    clear = 1'b1;
    part.delete();
    tick();
    clear = 1'b0;

    // Random traffic with random backpressure
    pushed = 0;
    cyc = 0;
    while ((pushed < 120 || sb.size() > 0) && cyc < 4000) begin
      tick();
      cyc++;
      blk_ready = 1'($urandom_range(0, 1));
      if (pushed < 120 && $urandom_range(0, 2) != 0) begin
        push_word($urandom);
        pushed++;
      end
    end
    if (sb.size() != 0) fail_now("random_drain");
    check("fifo_drained", fq.size(), 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
